// File: rtl/wb_initiator_pkg.sv
// Shared widths, FSM state type and response record for the Wishbone initiator.
// No logic; imported by the interface, the initiator and its bench.
package wb_initiator_pkg;

  localparam int ADR_WIDTH = 32;
  localparam int DAT_WIDTH = 32;
  localparam int SEL_WIDTH = DAT_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [DAT_WIDTH-1:0] dat;
    logic                 err;
    logic                 timeout;
  } rsp_t;

endpackage

// File: rtl/wb_initiator_if.sv
// Command/response streams plus the Wishbone master bus of one initiator.
// Signal suffixes are named from the initiator's point of view.
interface wb_initiator_if;
  import wb_initiator_pkg::*;

  logic                 cmd_valid_i;
  logic                 cmd_ready_o;
  logic                 cmd_we_i;
  logic [ADR_WIDTH-1:0] cmd_adr_i;
  logic [DAT_WIDTH-1:0] cmd_dat_i;
  logic [SEL_WIDTH-1:0] cmd_sel_i;

  logic                 rsp_valid_o;
  logic                 rsp_ready_i;
  logic [DAT_WIDTH-1:0] rsp_dat_o;
  logic                 rsp_err_o;
  logic                 rsp_timeout_o;

  logic                 cyc_o;
  logic                 stb_o;
  logic                 we_o;
  logic [ADR_WIDTH-1:0] adr_o;
  logic [DAT_WIDTH-1:0] dat_o;
  logic [SEL_WIDTH-1:0] sel_o;
  logic [DAT_WIDTH-1:0] dat_i;
  logic                 ack_i;
  logic                 err_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output cmd_ready_o,
    output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    input  rsp_ready_i,
    output cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    input  dat_i, ack_i, err_i
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  cmd_ready_o,
    input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
    output rsp_ready_i,
    input  cyc_o, stb_o, we_o, adr_o, dat_o, sel_o,
    output dat_i, ack_i, err_i
  );

endinterface

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone classic initiator: one command -> one bus cycle -> one response.
// Zero-wait slave gives rsp_valid one edge after accept; a stalled rsp_ready holds RESP and blocks new commands.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLOCKS = 16
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  wb_initiator_if.master  bus
);

  localparam bit          TO_EN   = (TIMEOUT_CLOCKS != 0);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CLOCKS) - 32'd1;

  state_e               state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic                 we_q, we_d;
  logic [ADR_WIDTH-1:0] adr_q, adr_d;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 rsp_vld_q, rsp_vld_d;
  rsp_t                 rsp_q, rsp_d;
  logic [31:0]          cnt_q, cnt_d;
  logic                 done;

  assign bus.cmd_ready_o   = (state_q == ST_IDLE);
  assign bus.cyc_o         = cyc_q;
  assign bus.stb_o         = cyc_q;
  assign bus.we_o          = we_q;
  assign bus.adr_o         = adr_q;
  assign bus.dat_o         = dat_q;
  assign bus.sel_o         = sel_q;
  assign bus.rsp_valid_o   = rsp_vld_q;
  assign bus.rsp_dat_o     = rsp_q.dat;
  assign bus.rsp_err_o     = rsp_q.err;
  assign bus.rsp_timeout_o = rsp_q.timeout;

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    rsp_vld_d = rsp_vld_q;
    rsp_d     = rsp_q;
    cnt_d     = cnt_q;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid_i) begin
          we_d    = bus.cmd_we_i;
          adr_d   = bus.cmd_adr_i;
          dat_d   = bus.cmd_dat_i;
          sel_d   = bus.cmd_sel_i;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        // err has priority over ack when a slave raises both
        if (bus.err_i) begin
          rsp_d = '{dat: '0, err: 1'b1, timeout: 1'b0};
          done  = 1'b1;
        end else if (bus.ack_i) begin
          rsp_d = '{dat: (we_q ? '0 : bus.dat_i), err: 1'b0, timeout: 1'b0};
          done  = 1'b1;
        end else if (TO_EN && (cnt_q == TO_LAST)) begin
          rsp_d = '{dat: '0, err: 1'b1, timeout: 1'b1};
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
        if (done) begin
          cyc_d     = 1'b0;
          rsp_vld_d = 1'b1;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready_i) begin
          rsp_vld_d     = 1'b0;
          rsp_d.err     = 1'b0;
          rsp_d.timeout = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      cyc_q     <= 1'b0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_vld_q <= 1'b0;
      rsp_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      cyc_q     <= cyc_d;
      we_q      <= we_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_q     <= rsp_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// Directed bench for wb_initiator: expected responses are queued at issue time and
// checked by an independent monitor on each response handshake.
module tb_wb_initiator;
  import wb_initiator_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wb_initiator_if bus();

  wb_initiator #(.TIMEOUT_CLOCKS(16)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Slave model: ack (or err+ack) after 'waits' wait states, or never.
  typedef enum logic [1:0] {M_ACK, M_ERR, M_NONE} smode_e;
  smode_e      mode    = M_ACK;
  int          waits   = 0;
  int          wcnt    = 0;
  logic        spur    = 1'b0;
  logic [31:0] slv_dat = '0;

  always @(posedge clk) begin
    if (!bus.stb_o) wcnt <= 0;
    else            wcnt <= wcnt + 1;
  end

  assign bus.ack_i = (bus.stb_o && mode != M_NONE && wcnt == waits) || spur;
  assign bus.err_i = bus.stb_o && mode == M_ERR && wcnt == waits;
  assign bus.dat_i = slv_dat;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  rsp_t sb[$];

  always @(negedge clk) begin : monitor
    rsp_t e;
    if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got dat %h err %b, no response expected",
                 bus.rsp_dat_o, bus.rsp_err_o);
      end else begin
        e = sb.pop_front();
        check("rsp_dat",     bus.rsp_dat_o,              e.dat);
        check("rsp_err",     32'(bus.rsp_err_o),         32'(e.err));
        check("rsp_timeout", 32'(bus.rsp_timeout_o),     32'(e.timeout));
      end
    end
  end

  // Called at a negedge; returns at the negedge where stb has dropped.
  task automatic run_cmd(input string tag, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input rsp_t exp, input int exp_len);
    int n, bad, t0, w;
    w = 0;
    while (!bus.cmd_ready_o && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_cmd_ready"}, 32'(bus.cmd_ready_o), 32'd1);
    if (!bus.cmd_ready_o) return;
    sb.push_back(exp);
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = we;
    bus.cmd_adr_i   = adr;
    bus.cmd_dat_i   = dat;
    bus.cmd_sel_i   = sel;
    @(posedge clk);
    #1;
    t0 = cyc_n;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = ~we;
    bus.cmd_adr_i   = ~adr;
    bus.cmd_dat_i   = ~dat;
    bus.cmd_sel_i   = ~sel;
    n   = 0;
    bad = 0;
    @(negedge clk);
    while (bus.stb_o && n < 100) begin
      n++;
      if ({bus.cyc_o, bus.we_o, bus.adr_o, bus.dat_o, bus.sel_o} !== {1'b1, we, adr, dat, sel})
        bad++;
      @(negedge clk);
    end
    check({tag, "_stb_len"},    32'(n),          32'(exp_len));
    check({tag, "_bus_stable"}, 32'(bad),        32'd0);
    check({tag, "_cyc_low"},    32'(bus.cyc_o),  32'd0);
    check({tag, "_rsp_valid"},  32'(bus.rsp_valid_o), 32'd1);
    check({tag, "_rsp_latency"}, 32'(cyc_n - t0), 32'(exp_len));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    bus.cmd_valid_i = 1'b0;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = '0;
    bus.cmd_dat_i   = '0;
    bus.cmd_sel_i   = '0;
    bus.rsp_ready_i = 1'b1;

    #1 rst_n = 1'b0;
    #2;
    check("rst_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("rst_cyc_stb",   32'({bus.cyc_o, bus.stb_o, bus.we_o}), 32'd0);
    check("rst_adr",       bus.adr_o, 32'd0);
    check("rst_dat_sel",   bus.dat_o | 32'(bus.sel_o), 32'd0);
    check("rst_rsp",       32'({bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_timeout_o}), 32'd0);
    check("rst_rsp_dat",   bus.rsp_dat_o, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: zero-wait read
    mode = M_ACK; waits = 0; slv_dat = 32'hDEADBEEF;
    run_cmd("t1", 1'b0, 32'h10, 32'h0, 4'hF, '{dat: 32'hDEADBEEF, err: 1'b0, timeout: 1'b0}, 1);
    @(negedge clk);

    // 2: write with three wait states; read data on the bus must not leak into rsp
    mode = M_ACK; waits = 3; slv_dat = 32'hFFFFFFFF;
    run_cmd("t2", 1'b1, 32'h20, 32'h12345678, 4'hF, '{dat: 32'h0, err: 1'b0, timeout: 1'b0}, 4);
    @(negedge clk);

    // 3: err and ack together on a read
    mode = M_ERR; waits = 1; slv_dat = 32'h55AA55AA;
    run_cmd("t3", 1'b0, 32'h24, 32'h0, 4'h3, '{dat: 32'h0, err: 1'b1, timeout: 1'b0}, 2);
    @(negedge clk);

    // 4: slave never answers -> timeout after 16 strobe cycles, then a normal read
    mode = M_NONE; waits = 0; slv_dat = 32'h11111111;
    run_cmd("t4", 1'b0, 32'h28, 32'h0, 4'hF, '{dat: 32'h0, err: 1'b1, timeout: 1'b1}, 16);
    @(negedge clk);
    mode = M_ACK; waits = 0; slv_dat = 32'h0BADCAFE;
    run_cmd("t4b", 1'b0, 32'h44, 32'h0, 4'hF, '{dat: 32'h0BADCAFE, err: 1'b0, timeout: 1'b0}, 1);
    @(negedge clk);

    // 5: response stalled five cycles with a spurious ack in RESP
    bus.rsp_ready_i = 1'b0;
    mode = M_ACK; waits = 0; slv_dat = 32'hCAFEF00D;
    run_cmd("t5", 1'b0, 32'h30, 32'h0, 4'hF, '{dat: 32'hCAFEF00D, err: 1'b0, timeout: 1'b0}, 1);
    slv_dat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", 32'(bus.rsp_valid_o), 32'd1);
      check("t5_hold_dat",   bus.rsp_dat_o, 32'hCAFEF00D);
      check("t5_hold_err",   32'({bus.rsp_err_o, bus.rsp_timeout_o}), 32'd0);
      check("t5_cmd_ready",  32'(bus.cmd_ready_o), 32'd0);
      check("t5_no_cyc",     32'(bus.cyc_o), 32'd0);
      @(posedge clk);
      #1;
      spur = (i == 1);
      if (i == 4) bus.rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check("t5_released", 32'({bus.rsp_valid_o, bus.cmd_ready_o}), 32'b01);

    // 6: asynchronous reset in the middle of a bus cycle
    mode = M_NONE;
    bus.cmd_valid_i = 1'b1;
    bus.cmd_we_i    = 1'b0;
    bus.cmd_adr_i   = 32'h50;
    bus.cmd_sel_i   = 4'hF;
    @(posedge clk);
    #1 bus.cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("t6_stb_before", 32'(bus.stb_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_cyc_stb_low", 32'({bus.cyc_o, bus.stb_o}), 32'd0);
    check("t6_rsp_valid",   32'(bus.rsp_valid_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t6_cmd_ready", 32'(bus.cmd_ready_o), 32'd1);
    check("t6_idle_bus",  32'({bus.cyc_o, bus.rsp_valid_o}), 32'd0);
    mode = M_ACK; waits = 2; slv_dat = 32'hA5A5_0001;
    run_cmd("t6b", 1'b0, 32'h54, 32'h0, 4'h1, '{dat: 32'hA5A50001, err: 1'b0, timeout: 1'b0}, 3);

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
